fmul_pipe: RTL and testbench

FMUL_PIPE -- requirements
Module: fmul_pipe

---
 rtl/fpu_pkg.sv | 26 ++
 rtl/fmul_round.sv | 40 ++++
 rtl/fmul_pipe.sv | 152 +++++++++++++++
 tb/tb_fmul_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared floating-point definitions: default binary32 field widths, operand
// classes, result kinds and the canonical quiet NaN.
package fpu_pkg;

   localparam int EW_DEF = 8;
   localparam int MW_DEF = 23;

   typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fclass_e;
   typedef enum logic [1:0] {RES_NUM, RES_ZERO, RES_INF, RES_QNAN} fres_e;

   // Canonical qNaN {0, all-ones exponent, 1, zeros}, right-aligned in 64 bits.
   function automatic logic [63:0] canon_nan(input int ew, input int mw);
      return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
   endfunction

   // Exponent-0 operands are flushed to zero, denormal or not.
   function automatic fclass_e classify(input logic exp_zero, input logic exp_ones,
                                        input logic man_zero);
      if (exp_zero)
         return ZERO;
      if (!exp_ones)
         return NORM;
      return man_zero ? INF : NAN;
   endfunction

endpackage

// File: rtl/fmul_round.sv
// Combinational normalise / round-to-nearest-even / exponent adjust for the
// hidden-one mantissa product of fmul_pipe.
module fmul_round
   import fpu_pkg::*;
#(
   parameter int EW = EW_DEF,
   parameter int MW = MW_DEF
) (
   input  logic [2*MW+1:0]      prod,
   input  logic signed [EW+1:0] exp_in,
   output logic [MW-1:0]        man,
   output logic signed [EW+1:0] exp_out
);

   localparam int PW = 2*MW + 2;

   function automatic logic rne_inc(input logic ulp, input logic guard, input logic sticky);
      return guard & (sticky | ulp);
   endfunction

   logic                 norm_carry;
   logic [PW-1:0]        norm;
   logic                 inc;
   logic [MW+1:0]        rsum;
   logic                 round_carry;
   logic signed [EW+1:0] adj;

   always_comb begin
      // Product lies in [1,4): align so the hidden one sits in the top bit.
      norm_carry  = prod[PW-1];
      norm        = norm_carry ? prod : {prod[PW-2:0], 1'b0};
      inc         = rne_inc(norm[MW+1], norm[MW], |norm[MW-1:0]);
      rsum        = {1'b0, norm[PW-1:MW+1]} + {{(MW+1){1'b0}}, inc};
      round_carry = rsum[MW+1];
      man         = round_carry ? rsum[MW:1] : rsum[MW-1:0];
      adj         = $signed({{(EW+1){1'b0}}, norm_carry}) + $signed({{(EW+1){1'b0}}, round_carry});
      exp_out     = exp_in + adj;
   end

endmodule

// File: rtl/fmul_pipe.sv
// Pipelined flush-to-zero floating-point multiplier with global stall
// back-pressure; STAGES (2..5) sets the latency in cycles.
module fmul_pipe
   import fpu_pkg::*;
#(
   parameter int EW     = EW_DEF,
   parameter int MW     = MW_DEF,
   parameter int STAGES = 3
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [EW+MW:0]  s,
   input  logic [EW+MW:0]  t,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [EW+MW:0]  d,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            overflow,
   output logic            underflow,
   output logic            invalid
);

   localparam int FW = 1 + EW + MW;
   localparam int PW = 2*MW + 2;
   localparam int XW = EW + 2;
   localparam int NQ = STAGES - 1;
   localparam logic signed [XW-1:0] BIAS     = XW'((1 << (EW-1)) - 1);
   localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EW) - 1);
   localparam logic signed [XW-1:0] EXP_ZERO = '0;
   localparam logic [FW-1:0]        QNAN     = FW'(canon_nan(EW, MW));

   logic                 adv;
   fclass_e              cls_s, cls_t;
   fres_e                kind_c;
   logic                 inv_c;
   logic                 sign_c;
   logic signed [XW-1:0] exp_c;
   logic [PW-1:0]        prod_c;

   logic                 vld_p1;
   logic                 sign_p1;
   fres_e                kind_p1;
   logic                 inv_p1;
   logic signed [XW-1:0] exp_p1;
   logic [PW-1:0]        prod_p1;

   logic [MW-1:0]        man_r;
   logic signed [XW-1:0] exp_r;
   logic [FW-1:0]        res_c;
   logic [2:0]           flg_c;

   logic                 vld_p2 [NQ];
   logic [FW-1:0]        res_p2 [NQ];
   logic [2:0]           flg_p2 [NQ];

   assign out_valid = vld_p2[NQ-1];
   assign in_ready  = !out_valid || out_ready;
   assign adv       = in_ready;
   assign d         = res_p2[NQ-1];
   assign overflow  = flg_p2[NQ-1][2] & out_valid;
   assign underflow = flg_p2[NQ-1][1] & out_valid;
   assign invalid   = flg_p2[NQ-1][0] & out_valid;

   // Stage 0 -> 1: classify operands, resolve specials, multiply mantissas.
   always_comb begin
      cls_s  = classify(s[FW-2:MW] == '0, &s[FW-2:MW], s[MW-1:0] == '0);
      cls_t  = classify(t[FW-2:MW] == '0, &t[FW-2:MW], t[MW-1:0] == '0);
      sign_c = s[FW-1] ^ t[FW-1];
      inv_c  = 1'b0;
      kind_c = RES_NUM;
      if (cls_s == NAN || cls_t == NAN) begin
         kind_c = RES_QNAN;
      end else if ((cls_s == INF && cls_t == ZERO) || (cls_s == ZERO && cls_t == INF)) begin
         kind_c = RES_QNAN;
         inv_c  = 1'b1;
      end else if (cls_s == INF || cls_t == INF) begin
         kind_c = RES_INF;
      end else if (cls_s == ZERO || cls_t == ZERO) begin
         kind_c = RES_ZERO;
      end
      exp_c  = $signed({2'b00, s[FW-2:MW]}) + $signed({2'b00, t[FW-2:MW]}) - BIAS;
      prod_c = {{(MW+1){1'b0}}, 1'b1, s[MW-1:0]} * {{(MW+1){1'b0}}, 1'b1, t[MW-1:0]};
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         sign_p1 <= sign_c;
         kind_p1 <= kind_c;
         inv_p1  <= inv_c;
         exp_p1  <= exp_c;
         prod_p1 <= prod_c;
      end
   end

   // Stage 1 -> 2: round, then range-check the final exponent.
   fmul_round #(
      .EW (EW),
      .MW (MW)
   ) u_round (
      .prod    (prod_p1),
      .exp_in  (exp_p1),
      .man     (man_r),
      .exp_out (exp_r)
   );

   always_comb begin
      res_c = {sign_p1, {(EW+MW){1'b0}}};
      flg_c = 3'b000;
      case (kind_p1)
         RES_QNAN: begin
            res_c    = QNAN;
            flg_c[0] = inv_p1;
         end
         RES_INF: res_c = {sign_p1, {EW{1'b1}}, {MW{1'b0}}};
         RES_NUM: begin
            if (exp_r >= EXP_MAX) begin
               res_c    = {sign_p1, {EW{1'b1}}, {MW{1'b0}}};
               flg_c[2] = 1'b1;
            end else if (exp_r <= EXP_ZERO) begin
               flg_c[1] = 1'b1;
            end else begin
               res_c = {sign_p1, exp_r[EW-1:0], man_r};
            end
         end
         default: res_c = {sign_p1, {(EW+MW){1'b0}}};
      endcase
   end

   // Stage 2 .. STAGES: result delay line; the last slot drives the outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld_p1 <= 1'b0;
         for (int i = 0; i < NQ; i++) begin
            vld_p2[i] <= 1'b0;
            res_p2[i] <= '0;
            flg_p2[i] <= '0;
         end
      end else if (adv) begin
         vld_p1    <= in_valid;
         vld_p2[0] <= vld_p1;
         res_p2[0] <= res_c;
         flg_p2[0] <= flg_c;
         for (int i = 1; i < NQ; i++) begin
            vld_p2[i] <= vld_p2[i-1];
            res_p2[i] <= res_p2[i-1];
            flg_p2[i] <= flg_p2[i-1];
         end
      end
   end

endmodule

// File: tb/tb_fmul_pipe.sv
// Bench for fmul_pipe: hand-computed binary32 vectors, back-pressure, mid-flight
// reset, and random operands against a double-precision FTZ reference.
`timescale 1ns/1ps
module tb_fmul_pipe #(parameter int STAGES = 3);

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] s = '0, t = '0, d;
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic        overflow, underflow, invalid;

   int checks = 0, failures = 0;
   int cyc = 0, stalls = 0, next_id = 0;
   logic [31:0] cur_d = '0;
   logic [2:0]  cur_f = '0;
   int          cur_id = 0;
   logic        rand_done = 1'b0;

   typedef struct {
      logic [31:0] d;
      logic [2:0]  f;
      int          id;
      int          cyc;
      int          stl;
   } exp_t;
   exp_t q[$];

   // {a, b, expected d, expected {overflow, underflow, invalid}}
   localparam int NV = 21;
   localparam logic [98:0] VEC [NV] = '{
      {32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000},
      {32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000},
      {32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100},
      {32'h00800000, 32'h00800000, 32'h00000000, 3'b010},
      {32'hFF800000, 32'h00000000, 32'h7FC00000, 3'b001},
      {32'h80000000, 32'h3F800000, 32'h80000000, 3'b000},
      {32'hFFC12345, 32'h3F800000, 32'h7FC00000, 3'b000},
      {32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000},
      {32'h00400000, 32'h3F800000, 32'h00000000, 3'b000},
      {32'hC0400000, 32'h40000000, 32'hC0C00000, 3'b000},
      {32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 3'b000},
      {32'h3F800800, 32'h3F800800, 32'h3F801000, 3'b000},
      {32'h3FC00000, 32'h3F800001, 32'h3FC00002, 3'b000},
      {32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 3'b000},
      {32'hFF000000, 32'h7F000000, 32'hFF800000, 3'b100},
      {32'h00800000, 32'h3F000000, 32'h00000000, 3'b010},
      {32'h00800000, 32'h3F800000, 32'h00800000, 3'b000},
      {32'h00000000, 32'h7F800001, 32'h7FC00000, 3'b000},
      {32'h80000000, 32'h7F800000, 32'h7FC00000, 3'b001},
      {32'h80800000, 32'h00800000, 32'h80000000, 3'b010},
      {32'h7F800000, 32'h7FC00000, 32'h7FC00000, 3'b000}
   };

   always #5 clk = ~clk;

   fmul_pipe #(
      .STAGES (STAGES)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .s         (s),
      .t         (t),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d         (d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overflow  (overflow),
      .underflow (underflow),
      .invalid   (invalid)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Scoreboard: record accepted ops, compare transfers in order with latency.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rstn) begin
         q.delete();
      end else begin
         if (q.size() == 0)
            chk("idle_out_valid", 64'(out_valid), 64'd0);
         chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
         if (out_valid && !out_ready)
            stalls++;
         if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("op%0d_d", e.id), 64'(d), 64'(e.d));
            chk($sformatf("op%0d_flags", e.id), 64'({overflow, underflow, invalid}), 64'(e.f));
            chk($sformatf("op%0d_latency", e.id), 64'(cyc - e.cyc), 64'(STAGES + stalls - e.stl));
         end
         if (in_valid && in_ready) begin
            e.d   = cur_d;
            e.f   = cur_f;
            e.id  = cur_id;
            e.cyc = cyc;
            e.stl = stalls;
            q.push_back(e);
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed, input logic [2:0] ef);
      int n = 0;
      s        = a;
      t        = b;
      cur_d    = ed;
      cur_f    = ef;
      cur_id   = next_id;
      next_id++;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 64) begin
         n++;
         @(negedge clk);
      end
      chk("issue_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic issue_vec(input int i);
      logic [98:0] v;
      v = VEC[i];
      issue(v[98:67], v[66:35], v[34:3], v[2:0]);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_d"}, 64'(d), 64'd0);
      chk({tag, "_flags"}, 64'({overflow, underflow, invalid}), 64'd0);
   endtask

   // Independent reference: the binary32 product is exact in double precision,
   // then rounded to 24 bits with ties-to-even and range-checked with FTZ.
   function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic        sg, za, zb, ia, ib, na, nb;
      logic [63:0] pb;
      logic [23:0] m;
      int          e;
      real         ra, rb;
      sg = a[31] ^ b[31];
      za = a[30:23] == 8'd0;
      zb = b[30:23] == 8'd0;
      ia = a[30:23] == 8'hFF && a[22:0] == 23'd0;
      ib = b[30:23] == 8'hFF && b[22:0] == 23'd0;
      na = a[30:23] == 8'hFF && a[22:0] != 23'd0;
      nb = b[30:23] == 8'hFF && b[22:0] != 23'd0;
      if (na || nb) return {3'b000, 32'h7FC00000};
      if ((ia && zb) || (za && ib)) return {3'b001, 32'h7FC00000};
      if (ia || ib) return {3'b000, sg, 8'hFF, 23'd0};
      if (za || zb) return {3'b000, sg, 31'd0};
      ra = $bitstoreal({1'b0, 11'(int'(a[30:23]) + 896), a[22:0], 29'd0});
      rb = $bitstoreal({1'b0, 11'(int'(b[30:23]) + 896), b[22:0], 29'd0});
      pb = $realtobits(ra * rb);
      e  = int'(pb[62:52]) - 1023 + 127;
      m  = {1'b0, pb[51:29]};
      if (pb[28] && ((|pb[27:0]) || pb[29]))
         m = m + 24'd1;
      if (m[23]) begin
         e++;
         m = 24'd0;
      end
      if (e >= 255) return {3'b100, sg, 8'hFF, 23'd0};
      if (e <= 0) return {3'b010, sg, 31'd0};
      return {3'b000, sg, 8'(e), m[22:0]};
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [7:0] e;
      if ($urandom_range(0, 9) == 0)
         e = 8'($urandom_range(0, 255));
      else
         e = 8'($urandom_range(60, 194));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   initial begin
      logic [31:0] a, b;
      logic [34:0] r;
      int          st0;

      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check_reset_state("rst");
      @(posedge clk);
      #1;

      // One op at a time, then the whole table back-to-back.
      for (int i = 0; i < NV; i++) begin
         issue_vec(i);
         drain();
      end
      for (int i = 0; i < NV; i++)
         issue_vec(i);
      drain();

      // Six ops with the consumer stalled for four cycles mid-stream.
      st0 = stalls;
      fork
         for (int i = 0; i < 6; i++)
            issue_vec(i);
         begin
            repeat (STAGES + 1) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_cycles", 64'(stalls - st0), 64'd4);

      // Reset with ops in flight: nothing stale may come out afterwards.
      for (int i = 0; i < 3; i++)
         issue_vec(i + 9);
      rstn = 1'b0;
      @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check_reset_state("midrst");
      repeat (8) @(negedge clk);
      @(posedge clk);
      #1;
      issue_vec(0);
      drain();

      // Random operands, random bubbles and random consumer back-pressure.
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               a = rnd_op();
               b = rnd_op();
               r = ref_mul(a, b);
               issue(a, b, r[31:0], r[34:32]);
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
